// File: rtl/cmac_tdm_pkg.sv
// Shared width helpers and mode encoding for the cmac_tdm block.
package cmac_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mode_t;

  function automatic int mult_bits(input int bitwidth, input int p_factor_bits);
    return 2 * bitwidth + 1 + p_factor_bits;
  endfunction

  function automatic int acc_bits(input int bitwidth, input int p_factor_bits,
                                  input int acc_len_bits);
    return mult_bits(bitwidth, p_factor_bits) + acc_len_bits;
  endfunction

endpackage

// File: rtl/cmac_tdm_cmult_par.sv
// Parallel complex multiply of P_FACTOR pairs summed through a registered binary tree.
// Latency is P_FACTOR_BITS+2 cycles: product stage, one stage per tree level, output stage.
module cmult_par
  import cmac_pkg::*;
#(
  parameter int BITWIDTH      = 4,
  parameter int P_FACTOR_BITS = 2
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               i_flush,
  input  logic                                               i_valid,
  input  logic                                               i_conj,
  input  logic [2*BITWIDTH*(1<<P_FACTOR_BITS)-1:0]           i_a,
  input  logic [2*BITWIDTH*(1<<P_FACTOR_BITS)-1:0]           i_b,
  output logic                                               o_valid,
  output logic signed [mult_bits(BITWIDTH, P_FACTOR_BITS)-1:0] o_re,
  output logic signed [mult_bits(BITWIDTH, P_FACTOR_BITS)-1:0] o_im
);
  localparam int P   = 1 << P_FACTOR_BITS;
  localparam int MB  = mult_bits(BITWIDTH, P_FACTOR_BITS);
  localparam int NN  = 2 * P - 1;
  localparam int LAT = P_FACTOR_BITS + 2;

  logic signed [MB-1:0] w_ar [P];
  logic signed [MB-1:0] w_ai [P];
  logic signed [MB-1:0] w_br [P];
  logic signed [MB-1:0] w_bi [P];
  logic signed [MB-1:0] w_pr [P];
  logic signed [MB-1:0] w_pi [P];
  logic signed [MB-1:0] r_nr [NN];
  logic signed [MB-1:0] r_ni [NN];
  logic signed [MB-1:0] r_re;
  logic signed [MB-1:0] r_im;
  logic [LAT-1:0]       r_vld;

  always_comb begin
    for (int k = 0; k < P; k++) begin
      w_ar[k] = MB'($signed(i_a[2*BITWIDTH*k+BITWIDTH +: BITWIDTH]));
      w_ai[k] = MB'($signed(i_a[2*BITWIDTH*k +: BITWIDTH]));
      w_br[k] = MB'($signed(i_b[2*BITWIDTH*k+BITWIDTH +: BITWIDTH]));
      w_bi[k] = MB'($signed(i_b[2*BITWIDTH*k +: BITWIDTH]));
      if (i_conj) begin
        w_pr[k] = w_ar[k] * w_br[k] + w_ai[k] * w_bi[k];
        w_pi[k] = w_ai[k] * w_br[k] - w_ar[k] * w_bi[k];
      end else begin
        w_pr[k] = w_ar[k] * w_br[k] - w_ai[k] * w_bi[k];
        w_pi[k] = w_ai[k] * w_br[k] + w_ar[k] * w_bi[k];
      end
    end
  end

  // Heap-ordered tree: leaves at P-1..2P-2, node i sums children 2i+1 and 2i+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NN; i++) begin
        r_nr[i] <= '0;
        r_ni[i] <= '0;
      end
      r_re  <= '0;
      r_im  <= '0;
      r_vld <= '0;
    end else begin
      for (int k = 0; k < P; k++) begin
        r_nr[P-1+k] <= w_pr[k];
        r_ni[P-1+k] <= w_pi[k];
      end
      for (int i = 0; i < P - 1; i++) begin
        r_nr[i] <= r_nr[2*i+1] + r_nr[2*i+2];
        r_ni[i] <= r_ni[2*i+1] + r_ni[2*i+2];
      end
      r_re  <= r_nr[0];
      r_im  <= r_ni[0];
      r_vld <= {r_vld[LAT-2:0] & {(LAT-1){~i_flush}}, i_valid};
    end
  end

  assign o_valid = r_vld[LAT-1];
  assign o_re    = r_re;
  assign o_im    = r_im;

endmodule

// File: rtl/cmac_tdm.sv
// Time-interleaved complex MAC: per-channel integration over acc_len+1 rounds.
// Define CMAC_TDM_SAT_EN for saturating accumulation with a sticky overflow flag.
module cmac_tdm
  import cmac_pkg::*;
#(
  parameter int BITWIDTH      = 4,
  parameter int P_FACTOR_BITS = 2,
  parameter int N_CHAN_BITS   = 2,
  parameter int ACC_LEN_BITS  = 7
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         sync,
  input  logic                                                         in_valid,
  input  logic [2*BITWIDTH*(1<<P_FACTOR_BITS)-1:0]                     a,
  input  logic [2*BITWIDTH*(1<<P_FACTOR_BITS)-1:0]                     b,
  input  logic                                                         conj,
  input  logic [ACC_LEN_BITS-1:0]                                      acc_len,
  output logic [2*acc_bits(BITWIDTH, P_FACTOR_BITS, ACC_LEN_BITS)-1:0] dout,
  output logic                                                         dout_valid,
  output logic [N_CHAN_BITS-1:0]                                       dout_chan,
  output logic                                                         overflow
);
  localparam int MB  = mult_bits(BITWIDTH, P_FACTOR_BITS);
  localparam int AB  = acc_bits(BITWIDTH, P_FACTOR_BITS, ACC_LEN_BITS);
  localparam int NCH = 1 << N_CHAN_BITS;

  mode_t                   r_mode;
  logic [N_CHAN_BITS-1:0]  r_chan;
  logic [ACC_LEN_BITS-1:0] r_round;
  logic [ACC_LEN_BITS-1:0] r_acc_len;
  logic signed [AB-1:0]    r_bank_re [NCH];
  logic signed [AB-1:0]    r_bank_im [NCH];
  logic [2*AB-1:0]         r_dout;
  logic                    r_dout_valid;
  logic [N_CHAN_BITS-1:0]  r_dout_chan;
  logic                    r_overflow;

  logic                    w_in_valid;
  logic                    w_prod_valid;
  logic                    w_pv;
  logic                    w_last;
  logic                    w_ovf;
  logic signed [MB-1:0]    w_mre;
  logic signed [MB-1:0]    w_mim;
  logic signed [AB-1:0]    w_pre;
  logic signed [AB-1:0]    w_pim;
  logic signed [AB-1:0]    w_sum_re;
  logic signed [AB-1:0]    w_sum_im;
  logic [AB:0]             w_add_re;
  logic [AB:0]             w_add_im;

`ifdef CMAC_TDM_SAT_EN
  // Returns {overflow, sum}; the sum clamps to the signed AB-bit range.
  function automatic logic [AB:0] sat_add(input logic signed [AB-1:0] x,
                                          input logic signed [AB-1:0] y);
    logic signed [AB:0] s;
    s = {x[AB-1], x} + {y[AB-1], y};
    if (s[AB] != s[AB-1]) begin
      sat_add = s[AB] ? {1'b1, 1'b1, {(AB-1){1'b0}}} : {1'b1, 1'b0, {(AB-1){1'b1}}};
    end else begin
      sat_add = {1'b0, s[AB-1:0]};
    end
  endfunction
`else
  function automatic logic [AB:0] sat_add(input logic signed [AB-1:0] x,
                                          input logic signed [AB-1:0] y);
    sat_add = {1'b0, x + y};
  endfunction
`endif

  assign w_in_valid = in_valid & (sync | (r_mode == RUN));
  assign w_pv       = w_prod_valid & ~sync;
  assign w_last     = (r_round == r_acc_len);

  cmult_par #(
    .BITWIDTH      (BITWIDTH),
    .P_FACTOR_BITS (P_FACTOR_BITS)
  ) u_cmult (
    .clk     (clk),
    .rst     (rst),
    .i_flush (sync),
    .i_valid (w_in_valid),
    .i_conj  (conj),
    .i_a     (a),
    .i_b     (b),
    .o_valid (w_prod_valid),
    .o_re    (w_mre),
    .o_im    (w_mim)
  );

  always_comb begin
    w_pre    = AB'(w_mre);
    w_pim    = AB'(w_mim);
    w_add_re = sat_add(r_bank_re[r_chan], w_pre);
    w_add_im = sat_add(r_bank_im[r_chan], w_pim);
    if (r_round == '0) begin
      w_sum_re = w_pre;
      w_sum_im = w_pim;
      w_ovf    = 1'b0;
    end else begin
      w_sum_re = $signed(w_add_re[AB-1:0]);
      w_sum_im = $signed(w_add_im[AB-1:0]);
      w_ovf    = w_add_re[AB] | w_add_im[AB];
    end
  end

  // sync restarts everything, including the pipeline (via i_flush) and the latched length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= IDLE;
      r_chan       <= '0;
      r_round      <= '0;
      r_acc_len    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_chan  <= '0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_bank_re[i] <= '0;
        r_bank_im[i] <= '0;
      end
    end else if (sync) begin
      r_mode       <= RUN;
      r_chan       <= '0;
      r_round      <= '0;
      r_acc_len    <= acc_len;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_bank_re[i] <= '0;
        r_bank_im[i] <= '0;
      end
    end else begin
      r_dout_valid <= 1'b0;
      if (w_pv) begin
        r_bank_re[r_chan] <= w_sum_re;
        r_bank_im[r_chan] <= w_sum_im;
        r_overflow        <= r_overflow | w_ovf;
        r_chan            <= r_chan + N_CHAN_BITS'(1);
        if (w_last) begin
          r_dout       <= {w_sum_re, w_sum_im};
          r_dout_valid <= 1'b1;
          r_dout_chan  <= r_chan;
        end else begin
          r_dout_chan  <= r_dout_chan;
        end
        if (r_chan == N_CHAN_BITS'(NCH - 1)) begin
          r_round <= w_last ? '0 : r_round + ACC_LEN_BITS'(1);
        end else begin
          r_round <= r_round;
        end
      end else begin
        r_chan <= r_chan;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_chan  = r_dout_chan;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_cmac_tdm.sv
// Self-checking bench for cmac_tdm (default parameters, CMAC_TDM_SAT_EN undefined).
module tb_cmac_tdm;
  localparam int LAT = 4;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        conj;
  logic [6:0]  acc_len;
  logic [35:0] dout;
  logic        dout_valid;
  logic [1:0]  dout_chan;
  logic        overflow;

  cmac_tdm dut (
    .clk        (clk),
    .rst        (rst),
    .sync       (sync),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .conj       (conj),
    .acc_len    (acc_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_chan  (dout_chan),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] dout;
    logic [1:0]  chan;
    int          due;
  } exp_t;

  typedef struct {
    logic [7:0] as;
    logic [7:0] bs;
    logic       cj;
    logic [6:0] len;
    bit         gap;
    bit         swf;
    int         ere;
    int         eim;
  } vec_t;

  exp_t   q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  bit     m_run   = 1'b0;
  int     m_ch;
  int     m_rnd;
  int     m_len;
  longint m_re [NCH];
  longint m_im [NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sum over the four lanes of the complex product, real part in the upper nibble.
  function automatic longint lane_sum(input logic [31:0] av, input logic [31:0] bv,
                                      input logic cj, input bit want_im);
    longint acc, ar, ai, br, bi;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      ar = longint'($signed(av[8*k+4 +: 4]));
      ai = longint'($signed(av[8*k +: 4]));
      br = longint'($signed(bv[8*k+4 +: 4]));
      bi = longint'($signed(bv[8*k +: 4]));
      if (want_im) acc += cj ? (ai*br - ar*bi) : (ai*br + ar*bi);
      else         acc += cj ? (ar*br + ai*bi) : (ar*br - ai*bi);
    end
    return acc;
  endfunction

  task automatic drive(input logic s, input logic v, input logic [31:0] av,
                       input logic [31:0] bv, input logic cj, input logic [6:0] al,
                       input bit use_exp, input int ere, input int eim);
    exp_t   e;
    longint pr, pi;
    @(posedge clk); #1;
    sync = s; in_valid = v; a = av; b = bv; conj = cj; acc_len = al;
    if (s) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      m_run = 1'b1; m_ch = 0; m_rnd = 0; m_len = int'(al);
    end
    if (v && m_run) begin
      pr = lane_sum(av, bv, cj, 1'b0);
      pi = lane_sum(av, bv, cj, 1'b1);
      if (m_rnd == 0) begin
        m_re[m_ch] = pr; m_im[m_ch] = pi;
      end else begin
        m_re[m_ch] += pr; m_im[m_ch] += pi;
      end
      if (m_rnd == m_len) begin
        e.dout = use_exp ? {18'(ere), 18'(eim)} : {18'(m_re[m_ch]), 18'(m_im[m_ch])};
        e.chan = 2'(m_ch);
        e.due  = cyc + LAT + 1;
        q.push_back(e);
      end
      if (m_ch == NCH - 1) begin
        m_ch = 0;
        m_rnd = (m_rnd == m_len) ? 0 : m_rnd + 1;
      end else begin
        m_ch++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, $urandom, 1'b0, 7'($urandom), 1'b0, 0, 0);
  endtask

  // Scoreboard monitor: dout_valid must appear exactly at each expected due cycle.
  initial begin
    exp_t e;
    bit   exp_v;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        if (dout_valid || exp_v) begin
          check("dout_valid", 64'(dout_valid), 64'(exp_v));
          if (exp_v) begin
            e = q.pop_front();
            if (dout_valid) begin
              check("dout", 64'(dout), 64'(e.dout));
              check("dout_chan", 64'(dout_chan), 64'(e.chan));
              check("overflow", 64'(overflow), 64'(1'b0));
            end
          end
        end
      end
    end
  end

  initial begin
    vec_t tv[8];
    int   nv, sent, p;
    bit   v;
    logic s;
    tv[0] = '{8'h11, 8'h11, 1'b0, 7'd3,   1'b0, 1'b1, 0,     32};
    tv[1] = '{8'h3E, 8'h3E, 1'b1, 7'd0,   1'b0, 1'b0, 52,    0};
    tv[2] = '{8'h11, 8'h11, 1'b0, 7'd1,   1'b1, 1'b0, 0,     16};
    tv[3] = '{8'h3E, 8'h12, 1'b0, 7'd2,   1'b0, 1'b0, 84,    48};
    tv[4] = '{8'h3E, 8'h12, 1'b1, 7'd2,   1'b0, 1'b0, -12,   -96};
    tv[5] = '{8'h88, 8'h88, 1'b1, 7'd127, 1'b0, 1'b0, 65536, 0};
    tv[6] = '{8'h87, 8'h78, 1'b0, 7'd0,   1'b0, 1'b0, 0,     452};
    tv[7] = '{8'h88, 8'h77, 1'b0, 7'd5,   1'b1, 1'b0, 0,     -2688};

    rst = 1'b1; sync = 1'b0; in_valid = 1'b0; a = '0; b = '0; conj = 1'b0; acc_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_dout_chan", 64'(dout_chan), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // IDLE: valid samples without a sync must produce nothing.
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, $urandom, $urandom, 1'b0, 7'd0, 1'b0, 0, 0);
    idle(LAT + 3);

    for (int t = 0; t < 8; t++) begin
      nv = NCH * (int'(tv[t].len) + 1);
      sent = 0;
      p = 0;
      if (!tv[t].swf) drive(1'b1, 1'b0, $urandom, $urandom, tv[t].cj, tv[t].len, 1'b1, 0, 0);
      while (sent < nv) begin
        v = !tv[t].gap || (p % 4 == 0) || (p % 4 == 3);
        s = tv[t].swf && (sent == 0);
        if (v) begin
          drive(s, 1'b1, {4{tv[t].as}}, {4{tv[t].bs}}, tv[t].cj,
                s ? tv[t].len : 7'($urandom), 1'b1, tv[t].ere, tv[t].eim);
          sent++;
        end else begin
          drive(1'b0, 1'b0, $urandom, $urandom, tv[t].cj, 7'($urandom), 1'b1, 0, 0);
        end
        p++;
      end
      idle(LAT + 3);
    end

    // Random data, random conj, occasional gaps.
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 7'd2, 1'b0, 0, 0);
    sent = 0;
    while (sent < 3 * NCH) begin
      v = ($urandom_range(3) != 0);
      drive(1'b0, v, $urandom, $urandom, 1'($urandom), 7'($urandom), 1'b0, 0, 0);
      if (v) sent++;
    end
    idle(LAT + 3);

    // Abort in round 2 of 4; the restart carries a sample in the same cycle.
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 7'd3, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 32'h77777777, 32'h77777777, 1'b0, 7'd3, 1'b0, 0, 0);
    drive(1'b1, 1'b1, $urandom, $urandom, 1'b0, 7'd1, 1'b0, 0, 0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 7'd0, 1'b0, 0, 0);
    idle(LAT + 3);

    // Products still in flight at sync are dropped.
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 7'd0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, $urandom, $urandom, 1'b0, 7'd0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 7'd1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 7'd0, 1'b0, 0, 0);
    idle(LAT + 3);

    // Reset mid-round, then ignored samples, then a fresh integration.
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 7'd1, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, $urandom, $urandom, 1'b0, 7'd0, 1'b0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; q.delete(); m_run = 1'b0;
    @(negedge clk);
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_dout_valid", 64'(dout_valid), 64'd0);
    check("midrst_dout_chan", 64'(dout_chan), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, $urandom, $urandom, 1'b0, 7'd0, 1'b0, 0, 0);
    idle(LAT + 3);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 7'd1, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 7'd0, 1'b0, 0, 0);
    idle(LAT + 3);

    @(negedge clk);
    check("final_dout_valid", 64'(dout_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
